// File: rtl/delay_combine_pipe.sv
// Configurable two-operand delay/combine pipeline: IN_DEPTH input stages per operand,
// a per-sample bitwise operator, OUT_DEPTH output stages, stall/flush and a saturating sample counter.
module delay_combine_pipe #(
    parameter int WIDTH     = 4,
    parameter int IN_DEPTH  = 3,
    parameter int OUT_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic [15:0]      out_count
);

    logic [IN_DEPTH-1:0]  r_in_vld;
    logic [WIDTH-1:0]     r_a    [IN_DEPTH];
    logic [WIDTH-1:0]     r_b    [IN_DEPTH];
    logic [1:0]           r_mode [IN_DEPTH];
    logic [OUT_DEPTH-1:0] r_out_vld;
    logic [WIDTH-1:0]     r_out_data [OUT_DEPTH];
    logic [15:0]          r_out_count;

    logic [WIDTH-1:0]     w_comb;
    logic [OUT_DEPTH:0]   w_vld_chain;
    logic                 w_final_in_vld;

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       m);
        case (m)
            2'd0:    return a & b;
            2'd1:    return ~a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Combine sits between the last input stage and the first output stage.
    assign w_comb = combine(r_a[IN_DEPTH-1], r_b[IN_DEPTH-1], r_mode[IN_DEPTH-1]);

    // Bit j is the valid entering output stage j; bit 0 comes from the input branch.
    assign w_vld_chain    = {r_out_vld, r_in_vld[IN_DEPTH-1]};
    assign w_final_in_vld = w_vld_chain[OUT_DEPTH-1];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_in_vld  <= '0;
            r_out_vld <= '0;
            for (int i = 0; i < IN_DEPTH; i++) begin
                r_a[i]    <= '0;
                r_b[i]    <= '0;
                r_mode[i] <= '0;
            end
            for (int j = 0; j < OUT_DEPTH; j++) begin
                r_out_data[j] <= '0;
            end
            if (!reset) begin
                r_out_count <= '0;
            end
        end else if (en) begin
            // Input branch: stage 0 captures the sample, bubbles load zero.
            r_in_vld[0] <= in_valid;
            r_a[0]      <= in_valid ? in1  : '0;
            r_b[0]      <= in_valid ? in2  : '0;
            r_mode[0]   <= in_valid ? mode : '0;
            for (int i = 1; i < IN_DEPTH; i++) begin
                r_in_vld[i] <= r_in_vld[i-1];
                r_a[i]      <= r_in_vld[i-1] ? r_a[i-1]    : '0;
                r_b[i]      <= r_in_vld[i-1] ? r_b[i-1]    : '0;
                r_mode[i]   <= r_in_vld[i-1] ? r_mode[i-1] : '0;
            end
            // Output branch.
            r_out_vld[0]  <= r_in_vld[IN_DEPTH-1];
            r_out_data[0] <= r_in_vld[IN_DEPTH-1] ? w_comb : '0;
            for (int j = 1; j < OUT_DEPTH; j++) begin
                r_out_vld[j]  <= r_out_vld[j-1];
                r_out_data[j] <= r_out_vld[j-1] ? r_out_data[j-1] : '0;
            end
            if (w_final_in_vld) begin
                r_out_count <= sat_inc(r_out_count);
            end
        end
    end

    assign out       = r_out_data[OUT_DEPTH-1];
    assign out_valid = r_out_vld[OUT_DEPTH-1];
    assign busy      = (|r_in_vld) | (|r_out_vld);
    assign out_count = r_out_count;

endmodule

// File: tb/tb_delay_combine_pipe.sv
// Directed bench for delay_combine_pipe: default-parameter instance driven from a vector table,
// plus a WIDTH=1/1+1-stage instance and a counter saturation run.
module tb_delay_combine_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in1 = '0;
    logic [3:0]  in2 = '0;
    logic [1:0]  mode = '0;
    logic [3:0]  out;
    logic        out_valid;
    logic        busy;
    logic [15:0] out_count;

    logic        in_valid2 = 1'b0;
    logic [0:0]  a2 = '0;
    logic [0:0]  b2 = '0;
    logic [1:0]  mode2 = '0;
    logic [0:0]  out2;
    logic        out_valid2;
    logic        busy2;
    logic [15:0] out_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_combine_pipe #(.WIDTH(4), .IN_DEPTH(3), .OUT_DEPTH(3)) u_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in1(in1), .in2(in2), .mode(mode), .out(out), .out_valid(out_valid),
        .busy(busy), .out_count(out_count)
    );

    delay_combine_pipe #(.WIDTH(1), .IN_DEPTH(1), .OUT_DEPTH(1)) u_dut_small (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid2),
        .in1(a2), .in2(b2), .mode(mode2), .out(out2), .out_valid(out_valid2),
        .busy(busy2), .out_count(out_count2)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        fl;
        logic        v;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [1:0]  m;
        logic [3:0]  e_out;
        logic        e_ov;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst_n, input logic e, input logic fl, input logic v,
                       input logic [3:0] a, input logic [3:0] b, input logic [1:0] m,
                       input logic [3:0] eo, input logic eov, input logic eb, input logic [15:0] ec);
        vec_t t;
        t = '{rst_n, e, fl, v, a, b, m, eo, eov, eb, ec};
        vq.push_back(t);
    endtask

    task automatic idle(input int n, input logic [3:0] eo, input logic eov,
                        input logic eb, input logic [15:0] ec);
        for (int k = 0; k < n; k++) add(1, 1, 0, 0, 4'h0, 4'h0, 2'd0, eo, eov, eb, ec);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low with valid input.
        add(0, 1, 0, 1, 4'hC, 4'hA, 2'd0, 4'h0, 0, 0, 16'd0);
        add(0, 1, 0, 1, 4'hC, 4'hA, 2'd1, 4'h0, 0, 0, 16'd0);
        // Latency and the four operators.
        for (int m = 0; m < 4; m++) add(1, 1, 0, 1, 4'hC, 4'hA, 2'(m), 4'h0, 0, 1, 16'd0);
        idle(1, 4'h0, 0, 1, 16'd0);
        idle(1, 4'h8, 1, 1, 16'd1);
        idle(1, 4'h2, 1, 1, 16'd2);
        idle(1, 4'hE, 1, 1, 16'd3);
        idle(1, 4'h6, 1, 1, 16'd4);
        idle(1, 4'h0, 0, 0, 16'd4);
        // Stall mid-flight, then a stall while the output burst is active.
        add(1, 1, 0, 1, 4'hC, 4'hA, 2'd0, 4'h0, 0, 1, 16'd4);
        add(1, 1, 0, 1, 4'hC, 4'hA, 2'd1, 4'h0, 0, 1, 16'd4);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 1, 4'hF, 4'hF, 2'd2, 4'h0, 0, 1, 16'd4);
        add(1, 1, 0, 1, 4'hC, 4'hA, 2'd2, 4'h0, 0, 1, 16'd4);
        add(1, 1, 0, 1, 4'hC, 4'hA, 2'd3, 4'h0, 0, 1, 16'd4);
        idle(1, 4'h0, 0, 1, 16'd4);
        idle(1, 4'h8, 1, 1, 16'd5);
        idle(1, 4'h2, 1, 1, 16'd6);
        add(1, 0, 0, 1, 4'hF, 4'h0, 2'd2, 4'h2, 1, 1, 16'd6);
        idle(1, 4'hE, 1, 1, 16'd7);
        idle(1, 4'h6, 1, 1, 16'd8);
        idle(1, 4'h0, 0, 0, 16'd8);
        // Flush (with en low) over four in-flight samples, then a normal sample.
        for (int m = 0; m < 4; m++) add(1, 1, 0, 1, 4'hC, 4'hA, 2'(m), 4'h0, 0, 1, 16'd8);
        add(1, 0, 1, 1, 4'hC, 4'hA, 2'd0, 4'h0, 0, 0, 16'd8);
        idle(6, 4'h0, 0, 0, 16'd8);
        add(1, 1, 0, 1, 4'hF, 4'h5, 2'd3, 4'h0, 0, 1, 16'd8);
        idle(4, 4'h0, 0, 1, 16'd8);
        idle(1, 4'hA, 1, 1, 16'd9);
        idle(1, 4'h0, 0, 0, 16'd9);
        // Reset mid-stream clears everything including the counter.
        for (int k = 0; k < 3; k++) add(1, 1, 0, 1, 4'hC, 4'hA, 2'd2, 4'h0, 0, 1, 16'd9);
        add(0, 1, 0, 1, 4'hC, 4'hA, 2'd0, 4'h0, 0, 0, 16'd0);

        for (int i = 0; i < vq.size(); i++) begin
            reset    = vq[i].rst_n;
            en       = vq[i].en;
            flush    = vq[i].fl;
            in_valid = vq[i].v;
            in1      = vq[i].a;
            in2      = vq[i].b;
            mode     = vq[i].m;
            step();
            chk($sformatf("v%0d_out", i),       32'(out),       32'(vq[i].e_out));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vq[i].e_busy));
            chk($sformatf("v%0d_out_count", i), 32'(out_count), 32'(vq[i].e_cnt));
        end

        // Small instance: latency of two edges, mode 1 and mode 0 with a=0, b=1.
        reset = 1; en = 1; flush = 0; in_valid = 0;
        in_valid2 = 1; a2 = 1'b0; b2 = 1'b1; mode2 = 2'd1;
        step();
        chk("small_lat_ov", 32'(out_valid2), 32'd0);
        chk("small_lat_busy", 32'(busy2), 32'd1);
        mode2 = 2'd0;
        step();
        chk("small_m1_out", 32'(out2), 32'd1);
        chk("small_m1_ov", 32'(out_valid2), 32'd1);
        chk("small_m1_cnt", 32'(out_count2), 32'd1);
        in_valid2 = 0;
        step();
        chk("small_m0_out", 32'(out2), 32'd0);
        chk("small_m0_ov", 32'(out_valid2), 32'd1);
        step();
        chk("small_idle_ov", 32'(out_valid2), 32'd0);
        chk("small_idle_busy", 32'(busy2), 32'd0);
        chk("small_idle_cnt", 32'(out_count2), 32'd2);

        // Counter saturation: 65540 back-to-back valids from an empty, cleared pipeline.
        reset = 0;
        step();
        reset = 1; in_valid = 1; in1 = 4'hC; in2 = 4'hA; mode = 2'd3;
        for (int n = 1; n <= 65540; n++) begin
            step();
            if (n == 65539) chk("sat_cnt_fffe", 32'(out_count), 32'h0000FFFE);
            if (n == 65540) begin
                chk("sat_cnt_ffff", 32'(out_count), 32'h0000FFFF);
                chk("sat_out", 32'(out), 32'h6);
            end
        end
        in_valid = 0;
        for (int k = 0; k < 8; k++) step();
        chk("sat_hold_cnt", 32'(out_count), 32'h0000FFFF);
        chk("sat_drain_busy", 32'(busy), 32'd0);
        flush = 1;
        step();
        flush = 0;
        chk("sat_flush_cnt", 32'(out_count), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
